// File: rtl/bus_pkg.sv
// Shared types for the core/DMA RAM arbiter: FSM states, bus-owner codes, counter sizing.
// Pure declarations; no logic, no latency, no backpressure.
package bus_pkg;

   typedef logic [15:0] addr_t;
   typedef logic [7:0]  data_t;

   typedef enum logic [1:0] {
      RST  = 2'd0,
      CPU  = 2'd1,
      DMA  = 2'd2,
      COOL = 2'd3
   } state_t;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_DMA = 1'b1
   } owner_t;

   // Bits needed to hold any value 0..n-1 (never less than one bit).
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Core, DMA and RAM bus signals of the arbiter; slave = arbiter view, master = surroundings.
// Wires only; no latency; flow control is the dma_req/dma_gnt level pair and cpu_hold.
interface bus_arbiter_if;
   import bus_pkg::*;

   addr_t cpu_address;
   data_t cpu_out;
   logic  cpu_we;
   data_t cpu_in;
   logic  cpu_hold;
   logic  cpu_reset_n;

   logic  dma_req;
   addr_t dma_address;
   data_t dma_out;
   logic  dma_we;
   logic  dma_gnt;
   data_t dma_in;

   addr_t mem_address;
   data_t mem_out;
   logic  mem_we;
   data_t mem_in;

   modport slave (
      input  cpu_address, cpu_out, cpu_we,
      output cpu_in, cpu_hold, cpu_reset_n,
      input  dma_req, dma_address, dma_out, dma_we,
      output dma_gnt, dma_in,
      output mem_address, mem_out, mem_we,
      input  mem_in
   );

   modport master (
      output cpu_address, cpu_out, cpu_we,
      input  cpu_in, cpu_hold, cpu_reset_n,
      output dma_req, dma_address, dma_out, dma_we,
      input  dma_gnt, dma_in,
      input  mem_address, mem_out, mem_we,
      output mem_in
   );

endinterface

// File: rtl/bus_arbiter_step_edge.sv
// Step rising-edge detector with a sticky pending flag cleared by consume.
// One cycle from step edge to pend; a new edge wins over a same-cycle consume.
module step_edge (
   input  logic clock,
   input  logic reset_n,
   input  logic step,
   input  logic arm,
   input  logic consume,
   output logic pend
);

   logic step_q;
   logic rise;

   assign rise = step & ~step_q & arm;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         step_q <= 1'b0;
         pend   <= 1'b0;
      end else begin
         step_q <= step;
         if (rise)
            pend <= 1'b1;
         else if (consume)
            pend <= 1'b0;
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Shares one async-read RAM between the 6502 core and a DMA master; sequences core reset and stepping.
// Zero-latency combinational mux; DMA waits one cycle for a grant, bursts capped then CPU gets a cooldown.
module bus_arbiter
   import bus_pkg::*;
#(
   parameter int RESET_CYCLES = 4,
   parameter int MAX_BURST    = 16,
   parameter int MIN_CPU      = 4
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        run,
   input  logic        step,
   bus_arbiter_if.slave bus
);

   localparam int CW = cnt_width(max_int(RESET_CYCLES, MIN_CPU));
   localparam int BW = cnt_width(MAX_BURST + 1);

   localparam logic [CW-1:0] RST_LOAD   = CW'(RESET_CYCLES - 1);
   localparam logic [CW-1:0] COOL_LOAD  = CW'(MIN_CPU - 1);
   localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

   state_t        state;
   logic [CW-1:0] cnt;
   logic [BW-1:0] burst;

   owner_t owner;
   logic   cpu_owned;
   logic   step_pend;
   logic   step_fire;

   assign owner     = (state == DMA) ? OWN_DMA : OWN_CPU;
   assign cpu_owned = (state == CPU) || (state == COOL);
   assign step_fire = cpu_owned & step_pend & ~run;

   // Any CPU-owned cycle retires a pending step: it either fires (run=0) or is moot (run=1).
   step_edge u_step_edge (
      .clock   (clock),
      .reset_n (reset_n),
      .step    (step),
      .arm     (state != RST),
      .consume (cpu_owned),
      .pend    (step_pend)
   );

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state <= RST;
         cnt   <= RST_LOAD;
         burst <= '0;
      end else begin
         case (state)
            RST: begin
               cnt <= cnt - CW'(1);
               if (cnt == '0)
                  state <= CPU;
            end
            CPU: begin
               if (bus.dma_req) begin
                  state <= DMA;
                  burst <= '0;
               end
            end
            DMA: begin
               burst <= burst + BW'(1);
               if (!bus.dma_req) begin
                  state <= CPU;
               end else if (burst == BURST_LAST) begin
                  state <= COOL;
                  cnt   <= COOL_LOAD;
               end
            end
            COOL: begin
               cnt <= cnt - CW'(1);
               if (cnt == '0)
                  state <= CPU;
            end
            default: begin
               state <= RST;
               cnt   <= RST_LOAD;
            end
         endcase
      end
   end

   always_comb begin
      bus.cpu_in      = bus.mem_in;
      bus.dma_in      = bus.mem_in;
      bus.cpu_reset_n = (state != RST);
      bus.dma_gnt     = 1'b0;
      bus.cpu_hold    = run | step_fire;
      bus.mem_address = bus.cpu_address;
      bus.mem_out     = bus.cpu_out;
      bus.mem_we      = bus.cpu_we;

      if (state == RST) begin
         // Core only samples reset while it is allowed to advance.
         bus.cpu_hold = 1'b1;
         bus.mem_we   = 1'b0;
      end else if (owner == OWN_DMA) begin
         // A frozen core write is simply masked; the core re-presents it after release.
         bus.dma_gnt     = 1'b1;
         bus.cpu_hold    = 1'b0;
         bus.mem_address = bus.dma_address;
         bus.mem_out     = bus.dma_out;
         bus.mem_we      = bus.dma_we;
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized bench for bus_arbiter: every cycle's outputs compared with an ownership/counter model.
// Inputs change on the falling edge; outputs sampled 1 ns later; model advances on the rising edge.
module tb_bus_arbiter;
   import bus_pkg::*;

   localparam int RESET_CYCLES = 4;
   localparam int MAX_BURST    = 16;
   localparam int MIN_CPU      = 4;
   localparam int N_CYCLES     = 3200;

   logic clock = 1'b0;
   logic reset_n;
   logic run;
   logic step;

   bus_arbiter_if bus ();

   bus_arbiter #(
      .RESET_CYCLES (RESET_CYCLES),
      .MAX_BURST    (MAX_BURST),
      .MIN_CPU      (MIN_CPU)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .run     (run),
      .step    (step),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   logic [7:0] ram     [0:255];
   logic [7:0] ref_ram [0:255];

   assign bus.mem_in = ram[bus.mem_address[7:0]];

   always @(posedge clock)
      if (bus.mem_we === 1'b1)
         ram[bus.mem_address[7:0]] <= bus.mem_out;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   // Model: who owns the bus and how many cycles remain in each forced phase.
   bit m_valid;
   bit m_in_reset;
   int m_reset_left;
   bit m_dma_owns;
   int m_grants;
   int m_cool_left;
   bit m_pend;
   bit m_prev_step;

   logic        e_rstn, e_hold, e_gnt, e_we;
   logic [15:0] e_addr;
   logic [7:0]  e_out;

   task automatic drive(input int c);
      bit want_req;
      bus.cpu_address = 16'($urandom);
      bus.cpu_out     = 8'($urandom);
      bus.cpu_we      = 1'($urandom_range(0, 1));
      reset_n = 1'b1;
      want_req = bus.dma_req;
      if (c < 3) begin
         reset_n = 1'b0; run = 1'b1; step = 1'b0; want_req = 1'b0;
      end else if (c < 40) begin
         run = 1'b1; want_req = 1'b0;
      end else if (c < 110) begin
         run = 1'b1; want_req = 1'b1;
      end else if (c < 200) begin
         run = 1'b0;
         if ($urandom_range(0, 2) == 0) step = ~step;
         if ($urandom_range(0, 9) == 0) want_req = ~want_req;
      end else if (c < 240) begin
         run = 1'b1; want_req = 1'b1;
         if (c == 210) reset_n = 1'b0;
      end else begin
         if ($urandom_range(0, 299) == 0) reset_n = 1'b0;
         if ($urandom_range(0, 39) == 0) run = ~run;
         if ($urandom_range(0, 3) == 0) step = ~step;
         if ($urandom_range(0, 7) == 0) want_req = ~want_req;
      end
      bus.dma_req     = want_req;
      bus.dma_address = ($urandom_range(0, 3) == 0) ? 16'h0200 : 16'($urandom);
      bus.dma_out     = ($urandom_range(0, 3) == 0) ? 8'h5A : 8'($urandom);
      bus.dma_we      = want_req ? 1'($urandom_range(0, 1)) : 1'b0;
   endtask

   task automatic expect_outputs();
      e_rstn = 1'b1;
      e_gnt  = 1'b0;
      e_addr = bus.cpu_address;
      e_out  = bus.cpu_out;
      e_we   = bus.cpu_we;
      e_hold = run | m_pend;
      if (m_in_reset) begin
         e_rstn = 1'b0;
         e_hold = 1'b1;
         e_we   = 1'b0;
      end else if (m_dma_owns) begin
         e_gnt  = 1'b1;
         e_hold = 1'b0;
         e_addr = bus.dma_address;
         e_out  = bus.dma_out;
         e_we   = bus.dma_we;
      end
   endtask

   task automatic advance_model();
      bit rise;
      if (!reset_n) begin
         m_valid      = 1'b1;
         m_in_reset   = 1'b1;
         m_reset_left = RESET_CYCLES;
         m_dma_owns   = 1'b0;
         m_grants     = 0;
         m_cool_left  = 0;
         m_pend       = 1'b0;
         m_prev_step  = 1'b0;
         return;
      end
      rise        = step & ~m_prev_step;
      m_prev_step = step;
      if (m_in_reset) begin
         m_reset_left--;
         if (m_reset_left == 0) m_in_reset = 1'b0;
      end else if (m_dma_owns) begin
         m_grants++;
         if (!bus.dma_req) begin
            m_dma_owns = 1'b0;
         end else if (m_grants == MAX_BURST) begin
            m_dma_owns  = 1'b0;
            m_cool_left = MIN_CPU;
         end
         m_pend = m_pend | rise;
      end else begin
         if (m_cool_left > 0) begin
            m_cool_left--;
         end else if (bus.dma_req) begin
            m_dma_owns = 1'b1;
            m_grants   = 0;
         end
         m_pend = rise;
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         ram[i]     = 8'($urandom);
         ref_ram[i] = ram[i];
      end
      m_valid     = 1'b0;
      m_in_reset  = 1'b0;
      m_dma_owns  = 1'b0;
      m_pend      = 1'b0;
      m_prev_step = 1'b0;
      reset_n = 1'b0;
      run     = 1'b1;
      step    = 1'b0;
      bus.dma_req = 1'b0;

      for (int c = 0; c < N_CYCLES; c++) begin
         @(negedge clock);
         drive(c);
         #1;
         if (m_valid) begin
            expect_outputs();
            chk("cpu_reset_n", 32'(bus.cpu_reset_n), 32'(e_rstn));
            chk("cpu_hold",    32'(bus.cpu_hold),    32'(e_hold));
            chk("dma_gnt",     32'(bus.dma_gnt),     32'(e_gnt));
            chk("mem_we",      32'(bus.mem_we),      32'(e_we));
            chk("mem_address", 32'(bus.mem_address), 32'(e_addr));
            if (!m_in_reset)
               chk("mem_out",  32'(bus.mem_out),     32'(e_out));
            chk("cpu_in",      32'(bus.cpu_in),      32'(ref_ram[e_addr[7:0]]));
            chk("dma_in",      32'(bus.dma_in),      32'(ref_ram[e_addr[7:0]]));
         end
         @(posedge clock);
         if (m_valid && e_we)
            ref_ram[e_addr[7:0]] = e_out;
         advance_model();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
